// File: rtl/ras_if.sv
// Return-address-stack port bundle: fetch update, retire update,
// flush, and the speculative top-of-stack outputs.
interface ras_if;
  logic        sp_vld_i;
  logic [1:0]  sp_ctl_i;
  logic [63:0] sp_push_addr_i;
  logic        rt_vld_i;
  logic [1:0]  rt_ctl_i;
  logic [63:0] rt_push_addr_i;
  logic        flush_i;
  logic [63:0] ras_top_o;
  logic        ras_vld_o;
  logic        ras_ovf_o;

  modport master (
    output sp_vld_i, sp_ctl_i, sp_push_addr_i,
    output rt_vld_i, rt_ctl_i, rt_push_addr_i,
    output flush_i,
    input  ras_top_o, ras_vld_o, ras_ovf_o
  );

  modport slave (
    input  sp_vld_i, sp_ctl_i, sp_push_addr_i,
    input  rt_vld_i, rt_ctl_i, rt_push_addr_i,
    input  flush_i,
    output ras_top_o, ras_vld_o, ras_ovf_o
  );
endinterface

// File: rtl/ras_stack.sv
// Return address stack with speculative (fetch) and committed (retire)
// copies; flush copies the committed next state into the speculative one.
module ras_stack #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset_n,
  ras_if.slave bus
);

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    POPPUSH = 2'b11
  } ctl_e;

  typedef struct packed {
    logic [DEPTH-1:0][63:0] stk;
    logic [PTR_W-1:0]       tos;
    logic [PTR_W:0]         cnt;
  } ras_t;

  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH-1);

  localparam ras_t RAS_RST = '{
    stk: '0,
    tos: TOS_RST,
    cnt: '0
  };

  ras_t sp_q, sp_d;
  ras_t rt_q, rt_d;
  logic ovf_q, ovf_d;
  logic sp_acc;

  // POPPUSH on an empty stack degenerates to a plain PUSH.
  function automatic ras_t upd(
    input ras_t        s,
    input logic        v,
    input ctl_e        ctl,
    input logic [63:0] a
  );
    ras_t             r;
    logic [PTR_W-1:0] up;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_rep;
    r       = s;
    up      = s.tos + PTR_W'(1);
    full    = (s.cnt == CNT_MAX);
    empty   = (s.cnt == '0);
    do_push = v & ((ctl == PUSH) |
                   ((ctl == POPPUSH) & empty));
    do_pop  = v & (ctl == POP) & ~empty;
    do_rep  = v & (ctl == POPPUSH) & ~empty;
    unique case (1'b1)
      do_push: begin
        r.tos     = up;
        r.stk[up] = a;
        if (!full)
          r.cnt = s.cnt + (PTR_W+1)'(1);
      end
      do_pop: begin
        r.tos = s.tos - PTR_W'(1);
        r.cnt = s.cnt - (PTR_W+1)'(1);
      end
      do_rep: begin
        r.stk[s.tos] = a;
      end
      default: ;
    endcase
    return r;
  endfunction

  assign sp_acc = bus.sp_vld_i & ~bus.flush_i;

  always_comb begin
    rt_d = upd(rt_q, bus.rt_vld_i,
               ctl_e'(bus.rt_ctl_i),
               bus.rt_push_addr_i);
    sp_d = upd(sp_q, sp_acc,
               ctl_e'(bus.sp_ctl_i),
               bus.sp_push_addr_i);
    if (bus.flush_i)
      sp_d = rt_d;
  end

  assign ovf_d = sp_acc &
                 (ctl_e'(bus.sp_ctl_i) == PUSH) &
                 (sp_q.cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= RAS_RST;
      rt_q  <= RAS_RST;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      rt_q  <= rt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.ras_top_o = sp_q.stk[sp_q.tos];
  assign bus.ras_vld_o = (sp_q.cnt != '0);
  assign bus.ras_ovf_o = ovf_q;

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack: push/pop, empty pop, overflow,
// flush restore, flush collisions, poppush and async reset.
module tb_ras_stack;
  logic clock;
  logic reset_n;
  int   passed;
  int   total;

  ras_if bus ();

  ras_stack #(.DEPTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.sp_vld_i       = 1'b0;
    bus.sp_ctl_i       = 2'b00;
    bus.sp_push_addr_i = '0;
    bus.rt_vld_i       = 1'b0;
    bus.rt_ctl_i       = 2'b00;
    bus.rt_push_addr_i = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic sp_op(input logic [1:0] c, input logic [63:0] a);
    idle();
    bus.sp_vld_i       = 1'b1;
    bus.sp_ctl_i       = c;
    bus.sp_push_addr_i = a;
    cyc();
    idle();
  endtask

  task automatic do_flush();
    idle();
    bus.flush_i = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #12;
    if (bus.ras_top_o !== 64'h0) begin
      $display("FAIL rst_top got %h exp %h", bus.ras_top_o, 64'h0);
    end else passed++;
    total++;
    if (bus.ras_vld_o !== 1'b0) begin
      $display("FAIL rst_vld got %b exp 0", bus.ras_vld_o);
    end else passed++;
    total++;
    if (bus.ras_ovf_o !== 1'b0) begin
      $display("FAIL rst_ovf got %b exp 0", bus.ras_ovf_o);
    end else passed++;
    total++;
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_push_pop();
    logic [1:0]  ctl [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic [63:0] adr [4] = '{64'h1000, 64'h2000, 64'h0, 64'h0};
    logic [63:0] etop[4] = '{64'h1000, 64'h2000, 64'h1000, 64'h0};
    logic        evld[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sp_op(ctl[i], adr[i]);
      if (evld[i] && bus.ras_top_o !== etop[i]) begin
        $display("FAIL pp_top%0d got %h exp %h", i, bus.ras_top_o, etop[i]);
      end else passed++;
      total++;
      if (bus.ras_vld_o !== evld[i]) begin
        $display("FAIL pp_vld%0d got %b exp %b", i, bus.ras_vld_o, evld[i]);
      end else passed++;
      total++;
    end
  endtask

  task automatic test_empty_pop();
    do_flush();
    sp_op(2'b10, 64'h0);
    if (bus.ras_vld_o !== 1'b0) begin
      $display("FAIL ep_vld got %b exp 0", bus.ras_vld_o);
    end else passed++;
    total++;
    if (dut.sp_q.tos !== 4'd15) begin
      $display("FAIL ep_tos got %0d exp 15", dut.sp_q.tos);
    end else passed++;
    total++;
    sp_op(2'b01, 64'hA0);
    if (bus.ras_top_o !== 64'hA0) begin
      $display("FAIL ep_top got %h exp a0", bus.ras_top_o);
    end else passed++;
    total++;
    if (dut.sp_q.cnt !== 5'd1) begin
      $display("FAIL ep_cnt got %0d exp 1", dut.sp_q.cnt);
    end else passed++;
    total++;
    if (dut.sp_q.stk[0] !== 64'hA0) begin
      $display("FAIL ep_stk0 got %h exp a0", dut.sp_q.stk[0]);
    end else passed++;
    total++;
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    do_flush();
    for (int k = 1; k <= 17; k++) begin
      sp_op(2'b01, 64'(k * 'h100));
      if (bus.ras_ovf_o === 1'b1) pulses++;
      if (bus.ras_ovf_o !== (k == 17)) begin
        $display("FAIL ovf_k%0d got %b exp %b", k, bus.ras_ovf_o, (k == 17));
      end else passed++;
      total++;
    end
    if (pulses !== 1) begin
      $display("FAIL ovf_pulses got %0d exp 1", pulses);
    end else passed++;
    total++;
    if (bus.ras_top_o !== 64'h1100) begin
      $display("FAIL ovf_top got %h exp 1100", bus.ras_top_o);
    end else passed++;
    total++;
    for (int i = 1; i <= 16; i++) begin
      sp_op(2'b10, 64'h0);
      if (bus.ras_ovf_o !== 1'b0) begin
        $display("FAIL ovf_pop_ovf%0d got %b exp 0", i, bus.ras_ovf_o);
      end else passed++;
      total++;
      if (i < 16) begin
        if (bus.ras_top_o !== 64'((17 - i) * 'h100)) begin
          $display("FAIL ovf_pop%0d got %h exp %h", i, bus.ras_top_o,
                   64'((17 - i) * 'h100));
        end else passed++;
        total++;
      end else begin
        if (bus.ras_vld_o !== 1'b0) begin
          $display("FAIL ovf_empty got %b exp 0", bus.ras_vld_o);
        end else passed++;
        total++;
      end
    end
  endtask

  task automatic test_flush_restore();
    do_flush();
    idle();
    bus.rt_vld_i       = 1'b1;
    bus.rt_ctl_i       = 2'b01;
    bus.rt_push_addr_i = 64'h4000;
    bus.sp_vld_i       = 1'b1;
    bus.sp_ctl_i       = 2'b01;
    bus.sp_push_addr_i = 64'h5000;
    cyc();
    sp_op(2'b01, 64'h6000);
    if (bus.ras_top_o !== 64'h6000) begin
      $display("FAIL fr_spec got %h exp 6000", bus.ras_top_o);
    end else passed++;
    total++;
    do_flush();
    if (bus.ras_top_o !== 64'h4000) begin
      $display("FAIL fr_top got %h exp 4000", bus.ras_top_o);
    end else passed++;
    total++;
    if (bus.ras_vld_o !== 1'b1) begin
      $display("FAIL fr_vld got %b exp 1", bus.ras_vld_o);
    end else passed++;
    total++;
  endtask

  task automatic test_flush_collide();
    idle();
    bus.rt_vld_i       = 1'b1;
    bus.rt_ctl_i       = 2'b01;
    bus.rt_push_addr_i = 64'h7000;
    bus.sp_vld_i       = 1'b1;
    bus.sp_ctl_i       = 2'b01;
    bus.sp_push_addr_i = 64'h8000;
    bus.flush_i        = 1'b1;
    cyc();
    idle();
    if (bus.ras_top_o !== 64'h7000) begin
      $display("FAIL fc_top got %h exp 7000", bus.ras_top_o);
    end else passed++;
    total++;
    if (bus.ras_ovf_o !== 1'b0) begin
      $display("FAIL fc_ovf got %b exp 0", bus.ras_ovf_o);
    end else passed++;
    total++;
    if (dut.sp_q.cnt !== 5'd2) begin
      $display("FAIL fc_cnt got %0d exp 2", dut.sp_q.cnt);
    end else passed++;
    total++;
    sp_op(2'b10, 64'h0);
    if (bus.ras_top_o !== 64'h4000) begin
      $display("FAIL fc_pop got %h exp 4000", bus.ras_top_o);
    end else passed++;
    total++;
  endtask

  task automatic test_poppush();
    sp_op(2'b01, 64'h3000);
    if (bus.ras_top_o !== 64'h3000) begin
      $display("FAIL pq_push got %h exp 3000", bus.ras_top_o);
    end else passed++;
    total++;
    idle();
    bus.sp_ctl_i       = 2'b01;
    bus.sp_push_addr_i = 64'hDEAD;
    cyc();
    idle();
    if (bus.ras_top_o !== 64'h3000) begin
      $display("FAIL pq_novld got %h exp 3000", bus.ras_top_o);
    end else passed++;
    total++;
    sp_op(2'b11, 64'h3100);
    if (bus.ras_top_o !== 64'h3100) begin
      $display("FAIL pq_top got %h exp 3100", bus.ras_top_o);
    end else passed++;
    total++;
    if (dut.sp_q.cnt !== 5'd2) begin
      $display("FAIL pq_cnt got %0d exp 2", dut.sp_q.cnt);
    end else passed++;
    total++;
    if (bus.ras_ovf_o !== 1'b0) begin
      $display("FAIL pq_ovf got %b exp 0", bus.ras_ovf_o);
    end else passed++;
    total++;
    sp_op(2'b10, 64'h0);
    if (bus.ras_top_o !== 64'h4000) begin
      $display("FAIL pq_pop got %h exp 4000", bus.ras_top_o);
    end else passed++;
    total++;
  endtask

  task automatic test_async_reset();
    sp_op(2'b01, 64'hC0);
    #2;
    reset_n = 1'b0;
    #1;
    if (bus.ras_top_o !== 64'h0 || bus.ras_vld_o !== 1'b0) begin
      $display("FAIL ar_out got %h/%b exp 0/0", bus.ras_top_o, bus.ras_vld_o);
    end else passed++;
    total++;
    #1;
    reset_n = 1'b1;
    sp_op(2'b01, 64'hB0);
    if (bus.ras_top_o !== 64'hB0) begin
      $display("FAIL ar_push got %h exp b0", bus.ras_top_o);
    end else passed++;
    total++;
    if (dut.sp_q.cnt !== 5'd1) begin
      $display("FAIL ar_cnt got %0d exp 1", dut.sp_q.cnt);
    end else passed++;
    total++;
    do_flush();
    if (bus.ras_vld_o !== 1'b0) begin
      $display("FAIL ar_commit got %b exp 0", bus.ras_vld_o);
    end else passed++;
    total++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset_n = 1'b1;
    idle();
    test_reset();
    test_push_pop();
    test_empty_pop();
    test_overflow();
    test_flush_restore();
    test_flush_collide();
    test_poppush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
